// File: rtl/zled_pkg.sv
// Shared definitions for the LED driver: command mode codes, channel FSM
// state encodings and a helper giving the steady LED level of a state.
package zled_pkg;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_FLASH = 2'd3;

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_ON    = 2'd1,
        S_BLINK = 2'd2,
        S_FLASH = 2'd3
    } state_t;

    // LED level on entry to a state (BLINK always starts lit).
    function automatic logic led_on_entry(state_t s);
        return (s != S_OFF);
    endfunction

endpackage

// File: rtl/zled_if.sv
// Command handshake bundle between fabric logic (master) and the LED driver (slave).
//   iCmdValid : command strobe
//   iCmdCh    : target channel
//   iCmdMode  : 0=OFF 1=ON 2=BLINK 3=FLASH
//   oCmdReady : driver accepts commands when high
interface zled_if;
    logic       iCmdValid;
    logic [1:0] iCmdCh;
    logic [1:0] iCmdMode;
    logic       oCmdReady;

    modport master (output iCmdValid, iCmdCh, iCmdMode, input oCmdReady);
    modport slave  (input iCmdValid, iCmdCh, iCmdMode, output oCmdReady);
endinterface

// File: rtl/zled_channel.sv
// One LED channel: mode FSM, millisecond counter and saved mode for FLASH restore.
//   iClk, iRst : clock, async active-high reset
//   iTick      : 1-cycle millisecond tick from the shared prescaler
//   iCmdStb    : command addressed to this channel was accepted this cycle
//   iCmdMode   : commanded mode
//   oLed       : registered LED drive, 1=lit
//   oFlashDone : registered 1-cycle pulse when a FLASH expires
module zled_channel
    import zled_pkg::*;
#(
    parameter int unsigned BLINK_MS = 250,
    parameter int unsigned FLASH_MS = 100
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iTick,
    input  logic       iCmdStb,
    input  logic [1:0] iCmdMode,
    output logic       oLed,
    output logic       oFlashDone
);

    localparam int unsigned MS_MAX = (BLINK_MS > FLASH_MS) ? BLINK_MS : FLASH_MS;
    localparam int unsigned CNT_W  = $clog2(MS_MAX + 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_MS - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_MS - 1);

    state_t           r_state;
    state_t           r_saved;
    logic [CNT_W-1:0] r_cnt;
    logic             r_led;
    logic             r_done;

    assign oLed       = r_led;
    assign oFlashDone = r_done;

    // A command always takes priority over tick-driven timing in the same cycle.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state <= S_OFF;
            r_saved <= S_OFF;
            r_cnt   <= '0;
            r_led   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (iCmdStb) begin
                r_cnt <= '0;
                case (iCmdMode)
                    MODE_OFF: begin
                        r_state <= S_OFF;
                        r_led   <= 1'b0;
                    end
                    MODE_ON: begin
                        r_state <= S_ON;
                        r_led   <= 1'b1;
                    end
                    MODE_BLINK: begin
                        r_state <= S_BLINK;
                        r_led   <= 1'b1;
                    end
                    default: begin
                        // Re-flashing keeps the mode saved by the first FLASH.
                        if (r_state != S_FLASH) begin
                            r_saved <= r_state;
                        end
                        r_state <= S_FLASH;
                        r_led   <= 1'b1;
                    end
                endcase
            end else if (iTick) begin
                case (r_state)
                    S_BLINK: begin
                        if (r_cnt == BLINK_LAST) begin
                            r_led <= ~r_led;
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    S_FLASH: begin
                        if (r_cnt == FLASH_LAST) begin
                            r_state <= r_saved;
                            r_led   <= led_on_entry(r_saved);
                            r_cnt   <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/zled_driver.sv
// NUM_CH indicator LED driver: shared millisecond prescaler, command decode
// and one zled_channel per LED.
//   iClk, iRst : clock, async active-high reset
//   cmd        : command handshake (zled_if slave)
//   oLed       : registered LED drive, 1=lit
//   oFlashDone : per-channel 1-cycle pulse on FLASH expiry
module zled_driver
    import zled_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned BLINK_MS = 250,
    parameter int unsigned FLASH_MS = 100
) (
    input  logic              iClk,
    input  logic              iRst,
    zled_if.slave             cmd,
    output logic [NUM_CH-1:0] oLed,
    output logic [NUM_CH-1:0] oFlashDone
);

    localparam int unsigned PRE_W = $clog2(TICK_DIV);

    logic [PRE_W-1:0]  r_pre;
    logic              r_ready;
    logic              w_tick;
    logic              w_accept;
    logic [NUM_CH-1:0] w_stb;

    assign w_tick        = (r_pre == PRE_W'(TICK_DIV - 1));
    assign w_accept      = cmd.iCmdValid & r_ready;
    assign cmd.oCmdReady = r_ready;

    // Free-running prescaler; only reset clears it.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_pre <= '0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
        end
    end

    // Ready rises on the first clock after reset release.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b1;
        end
    end

    // Channel numbers at or above NUM_CH match no strobe and are dropped.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_stb[g] = w_accept & (cmd.iCmdCh == 2'(g));

        zled_channel #(
            .BLINK_MS (BLINK_MS),
            .FLASH_MS (FLASH_MS)
        ) u_ch (
            .iClk       (iClk),
            .iRst       (iRst),
            .iTick      (w_tick),
            .iCmdStb    (w_stb[g]),
            .iCmdMode   (cmd.iCmdMode),
            .oLed       (oLed[g]),
            .oFlashDone (oFlashDone[g])
        );
    end

endmodule
